// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access unit: transfer sizes, FSM states
// and the default memory size.
package mem_access_pkg;

    localparam int MEM_BYTES_DEFAULT = 128;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WSETUP,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/byte_lane_align.sv
// Big-endian lane steering between a memory word and a right-aligned operand:
// load direction extracts and extends, store direction merges into the old word.
module byte_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Byte offset 0 is the most significant lane of the word.
    always_comb begin
        lane_byte = mem_word[31:24];
        case (offset)
            2'd0: lane_byte = mem_word[31:24];
            2'd1: lane_byte = mem_word[23:16];
            2'd2: lane_byte = mem_word[15:8];
            2'd3: lane_byte = mem_word[7:0];
            default: lane_byte = mem_word[31:24];
        endcase
        lane_half = offset[1] ? mem_word[15:0] : mem_word[31:16];
    end

    always_comb begin
        load_data = mem_word;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{sign_ext & lane_half[15]}}, lane_half};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0: merged_word = {wdata[7:0], mem_word[23:0]};
                    2'd1: merged_word = {mem_word[31:24], wdata[7:0], mem_word[15:0]};
                    2'd2: merged_word = {mem_word[31:16], wdata[7:0], mem_word[7:0]};
                    2'd3: merged_word = {mem_word[31:8], wdata[7:0]};
                    default: merged_word = mem_word;
                endcase
            end
            SZ_HALF: merged_word = offset[1] ? {mem_word[31:16], wdata[15:0]}
                                             : {wdata[15:0], mem_word[15:0]};
            default: merged_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator for the multicycle CPU: sequences byte/half/word loads and
// stores (partial stores as read-modify-write) onto an active-low RD/WR word port.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] DAddr,
    output logic [31:0] DataIn,
    output logic        RD,
    output logic        WR,
    input  logic [31:0] DataOut
);
    state_e state;
    state_e next_state;

    logic        accept;
    logic        req_err;
    logic        is_store_q;
    logic        sign_ext_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign accept = (state == IDLE) && req;

    // Checks are prioritised so an illegal size is reported before alignment.
    always_comb begin
        req_err = 1'b0;
        if (size == SZ_ILLEGAL) begin
            req_err = 1'b1;
        end else if ((size == SZ_HALF) && addr[0]) begin
            req_err = 1'b1;
        end else if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end else if (addr >= 32'(MEM_BYTES)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (req_err) begin
                        next_state = DONE;
                    end else if (is_store && (size == SZ_WORD)) begin
                        next_state = WSETUP;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = is_store_q ? WSETUP : DONE;
            WSETUP:  next_state = WRITE;
            WRITE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    byte_lane_align u_align (
        .mem_word    (DataOut),
        .size        (size_q),
        .offset      (offset_q),
        .sign_ext    (sign_ext_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Strobes are decoded from the next state so they are glitch-free registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            RD         <= 1'b1;
            WR         <= 1'b1;
            DAddr      <= 32'd0;
            DataIn     <= 32'd0;
            rdata      <= 32'd0;
            is_store_q <= 1'b0;
            sign_ext_q <= 1'b0;
            err_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            offset_q   <= 2'd0;
            wdata_q    <= 32'd0;
        end else begin
            state <= next_state;
            RD    <= (next_state != READ);
            WR    <= (next_state != WRITE);

            if (accept) begin
                is_store_q <= is_store;
                sign_ext_q <= sign_ext;
                size_q     <= size;
                offset_q   <= addr[1:0];
                wdata_q    <= wdata;
                err_q      <= req_err;
                DAddr      <= {2'b00, addr[31:2]};
                if (!req_err && is_store && (size == SZ_WORD)) begin
                    DataIn <= wdata;
                end
            end

            // The word read back in READ feeds either the load result or the merge.
            if (state == READ) begin
                if (is_store_q) begin
                    DataIn <= merged_word;
                end else begin
                    rdata <= load_data;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign ack  = (state == DONE);
    assign err  = (state == DONE) && err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model, directed vector table,
// multi-cycle corner sequences and a randomized phase.
module tb_mem_access_unit;

    localparam int MEM = 128;

    logic        CLK;
    logic        Reset;
    logic        req;
    logic        is_store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] DAddr;
    logic [31:0] DataIn;
    logic        RD;
    logic        WR;
    logic [31:0] DataOut;

    int n_vec;
    int n_fail;

    logic [7:0]  ref_mem [0:MEM-1];
    logic [31:0] dev_mem [0:MEM/4-1];
    logic [31:0] exp_rdata;

    mem_access_unit #(.MEM_BYTES(MEM)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .req      (req),
        .is_store (is_store),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .DAddr    (DAddr),
        .DataIn   (DataIn),
        .RD       (RD),
        .WR       (WR),
        .DataOut  (DataOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Word-addressed big-endian memory; the write lands on the falling edge.
    assign DataOut = (DAddr < 32'(MEM / 4)) ? dev_mem[DAddr[4:0]] : 32'hDEADBEEF;

    always @(negedge CLK) begin
        if (!WR && (DAddr < 32'(MEM / 4))) dev_mem[DAddr[4:0]] = DataIn;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h", name, got, expv);
        end
    endtask

    function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        int n;
        longint v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[int'(a) + i]);
        if (sx && (v >= (longint'(1) << (8 * n - 1)))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output int lat, output logic got_err, output logic [31:0] got_rdata,
                                 output logic [7:0] rdm, output logic [7:0] wrm,
                                 output logic [31:0] got_daddr, output logic busy_all);
        @(negedge CLK);
        req = 1'b1; is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge CLK);
        #1 req = 1'b0;
        lat = -1; got_err = 1'b0; got_rdata = 32'd0; rdm = 8'd0; wrm = 8'd0;
        got_daddr = 32'd0; busy_all = 1'b1;
        for (int c = 0; c < 8 && lat < 0; c++) begin
            @(negedge CLK);
            if (c == 0) got_daddr = DAddr;
            if (!RD) rdm[c] = 1'b1;
            if (!WR) wrm[c] = 1'b1;
            if (!busy) busy_all = 1'b0;
            if (ack) begin
                lat = c;
                got_err = err;
                got_rdata = rdata;
            end
        end
    endtask

    task automatic runTxn(input string name, input logic st, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic o_err, output logic [31:0] o_rdata, output int o_lat);
        int n;
        logic e_err;
        int e_lat;
        logic [7:0] e_rdm;
        logic [7:0] e_wrm;
        logic [7:0] rdm;
        logic [7:0] wrm;
        logic [31:0] got_daddr;
        logic busy_all;
        n = 1 << sz;
        e_err = (sz == 2'd3) ? 1'b1 : ((a >= 32'(MEM)) || ((a % 32'(n)) != 0));
        e_lat = e_err ? 0 : (!st ? 1 : (n == 4 ? 2 : 3));
        e_rdm = (!e_err && (!st || n < 4)) ? 8'h01 : 8'h00;
        e_wrm = (!e_err && st) ? ((n == 4) ? 8'h02 : 8'h04) : 8'h00;
        if (!e_err && !st) exp_rdata = modelLoad(sz, sx, a);
        applyStimulus(st, sz, sx, a, wd, o_lat, o_err, o_rdata, rdm, wrm, got_daddr, busy_all);
        checkOutput({name, ".lat"}, 32'(o_lat), 32'(e_lat));
        checkOutput({name, ".err"}, {31'd0, o_err}, {31'd0, e_err});
        checkOutput({name, ".rdata"}, o_rdata, exp_rdata);
        checkOutput({name, ".rd_cycles"}, {24'd0, rdm}, {24'd0, e_rdm});
        checkOutput({name, ".wr_cycles"}, {24'd0, wrm}, {24'd0, e_wrm});
        checkOutput({name, ".daddr"}, got_daddr, a >> 2);
        checkOutput({name, ".busy"}, {31'd0, busy_all}, 32'd1);
        if (!e_err && st) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
        end
    endtask

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat;
    } vec_t;

    vec_t vt [0:21];

    initial begin
        logic        o_err;
        logic [31:0] o_rdata;
        int          o_lat;
        logic [11:0] busy_v;
        logic [11:0] ack_v;
        logic [11:0] e_busy_v;
        logic [11:0] e_ack_v;
        logic        wr_seen;
        logic [1:0]  sz;
        logic [31:0] a;

        n_vec = 0;
        n_fail = 0;
        req = 1'b0; is_store = 1'b0; size = 2'd0; sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;
        Reset = 1'b1;
        for (int i = 0; i < MEM; i++) ref_mem[i] = 8'($urandom);
        for (int w = 0; w < MEM / 4; w++)
            dev_mem[w] = {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};
        exp_rdata = 32'd0;

        vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h00000000, 2};
        vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'h11223344, 1};
        vt[2]  = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 1'b0, 32'h11223344, 3};
        vt[3]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'h1122BEEF, 1};
        vt[4]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h112233F4, 1'b0, 32'h1122BEEF, 2};
        vt[5]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        1'b0, 32'hFFFFFFF4, 1};
        vt[6]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        1'b0, 32'h000000F4, 1};
        vt[7]  = '{1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        1'b0, 32'h00000011, 1};
        vt[8]  = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        1'b0, 32'h00001122, 1};
        vt[9]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFFA5, 1'b0, 32'h00001122, 3};
        vt[10] = '{1'b0, 2'd0, 1'b1, 32'h11, 32'h0,        1'b0, 32'hFFFFFFA5, 1};
        vt[11] = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        1'b1, 32'hFFFFFFA5, 0};
        vt[12] = '{1'b1, 2'd2, 1'b0, 32'h12, 32'h0,        1'b1, 32'hFFFFFFA5, 0};
        vt[13] = '{1'b0, 2'd0, 1'b0, 32'h80, 32'h0,        1'b1, 32'hFFFFFFA5, 0};
        vt[14] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        1'b1, 32'hFFFFFFA5, 0};
        vt[15] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'h11A533F4, 1};
        vt[16] = '{1'b1, 2'd0, 1'b0, 32'h7F, 32'h0000005A, 1'b0, 32'h11A533F4, 3};
        vt[17] = '{1'b0, 2'd0, 1'b1, 32'h7F, 32'h0,        1'b0, 32'h0000005A, 1};
        vt[18] = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        1'b0, 32'h000033F4, 1};
        vt[19] = '{1'b1, 2'd1, 1'b0, 32'h7E, 32'h00008001, 1'b0, 32'h000033F4, 3};
        vt[20] = '{1'b0, 2'd1, 1'b1, 32'h7E, 32'h0,        1'b0, 32'hFFFF8001, 1};
        vt[21] = '{1'b0, 2'd0, 1'b0, 32'h7F, 32'h0,        1'b0, 32'h00000001, 1};

        repeat (2) @(negedge CLK);
        checkOutput("reset.RD", {31'd0, RD}, 32'd1);
        checkOutput("reset.WR", {31'd0, WR}, 32'd1);
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);
        checkOutput("reset.ack", {31'd0, ack}, 32'd0);
        checkOutput("reset.err", {31'd0, err}, 32'd0);
        checkOutput("reset.rdata", rdata, 32'd0);
        checkOutput("reset.DAddr", DAddr, 32'd0);
        checkOutput("reset.DataIn", DataIn, 32'd0);
        Reset = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 22; i++) begin
            runTxn($sformatf("vec%0d", i), vt[i].st, vt[i].sz, vt[i].sx, vt[i].a, vt[i].wd,
                   o_err, o_rdata, o_lat);
            checkOutput($sformatf("vec%0d.tbl_err", i), {31'd0, o_err}, {31'd0, vt[i].e_err});
            checkOutput($sformatf("vec%0d.tbl_rdata", i), o_rdata, vt[i].e_rdata);
            checkOutput($sformatf("vec%0d.tbl_lat", i), 32'(o_lat), 32'(vt[i].e_lat));
        end

        // req held high: one word load per pass, busy low one cycle between passes.
        exp_rdata = modelLoad(2'd2, 1'b0, 32'h10);
        @(negedge CLK);
        req = 1'b1; is_store = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h10; wdata = 32'd0;
        @(posedge CLK);
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            busy_v[c] = busy;
            ack_v[c] = ack;
            e_busy_v[c] = ((c % 3) != 2);
            e_ack_v[c] = ((c % 3) == 1);
        end
        req = 1'b0;
        checkOutput("req_held.busy", {20'd0, busy_v}, {20'd0, e_busy_v});
        checkOutput("req_held.ack", {20'd0, ack_v}, {20'd0, e_ack_v});
        checkOutput("req_held.rdata", rdata, exp_rdata);

        // Reset during WSETUP of a word store: write must be abandoned.
        @(negedge CLK);
        req = 1'b1; is_store = 1'b1; size = 2'd2; sign_ext = 1'b0; addr = 32'h20; wdata = 32'hCAFEF00D;
        @(posedge CLK);
        #1 req = 1'b0;
        #1 Reset = 1'b1;
        #1;
        checkOutput("midreset.WR", {31'd0, WR}, 32'd1);
        checkOutput("midreset.RD", {31'd0, RD}, 32'd1);
        checkOutput("midreset.busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset.ack", {31'd0, ack}, 32'd0);
        checkOutput("midreset.rdata", rdata, 32'd0);
        checkOutput("midreset.DAddr", DAddr, 32'd0);
        checkOutput("midreset.DataIn", DataIn, 32'd0);
        wr_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (!WR) wr_seen = 1'b1;
        end
        Reset = 1'b0;
        checkOutput("midreset.wr_seen", {31'd0, wr_seen}, 32'd0);
        exp_rdata = 32'd0;
        runTxn("midreset.load", 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, o_err, o_rdata, o_lat);

        for (int i = 0; i < 60; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(128, 300));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, 127));
            endcase
            if ((sz != 2'd3) && ($urandom_range(0, 3) != 0)) a = a & ~((32'd1 << sz) - 32'd1);
            runTxn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   a, $urandom, o_err, o_rdata, o_lat);
        end

        for (int w = 0; w < MEM / 4; w++) begin
            runTxn($sformatf("sweep%0d", w), 1'b0, 2'd2, 1'b0, 32'(4 * w), 32'd0, o_err, o_rdata, o_lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
